// File: rtl/ct_fadd_close_lza_pipe_if.sv
// Close-path subtractor bundle: EX1 operands and pipeline control in,
// EX2 (difference + LZA prediction) and EX3 (normalised result) out.
interface ct_fadd_close_lza_pipe_if #(
  parameter int WIDTH = 11,
  parameter int CNT_W = $clog2(WIDTH)
);
  logic             ex1_vld;
  logic [WIDTH-1:0] ex1_adder0;
  logic [WIDTH-1:0] ex1_adder1;
  logic             pipe_stall;
  logic             pipe_flush;

  logic             ex2_vld;
  logic [WIDTH-1:0] ex2_sum;
  logic             ex2_op_chg;
  logic             ex2_eq;
  logic [CNT_W-1:0] ex2_ff1_pred;

  logic             ex3_vld;
  logic [WIDTH-1:0] ex3_norm_sum;
  logic [CNT_W-1:0] ex3_lz_cnt;
  logic             ex3_zero;
  logic             ex3_op_chg;
  logic             ex3_lza_corr;

  // upstream side: drives operands and pipeline control
  modport master (
    output ex1_vld, ex1_adder0, ex1_adder1, pipe_stall, pipe_flush,
    input  ex2_vld, ex2_sum, ex2_op_chg, ex2_eq, ex2_ff1_pred,
    input  ex3_vld, ex3_norm_sum, ex3_lz_cnt, ex3_zero, ex3_op_chg, ex3_lza_corr
  );

  // subtractor side
  modport slave (
    input  ex1_vld, ex1_adder0, ex1_adder1, pipe_stall, pipe_flush,
    output ex2_vld, ex2_sum, ex2_op_chg, ex2_eq, ex2_ff1_pred,
    output ex3_vld, ex3_norm_sum, ex3_lz_cnt, ex3_zero, ex3_op_chg, ex3_lza_corr
  );
endinterface

// File: rtl/ct_fadd_close_lza_pipe.sv
// Close-path mantissa subtractor for the vector FP adder.
// EX1: |A-B|, sign flip, equality and leading-one anticipation.
// EX2: normalise by the predicted count, fixing the one-short prediction case.
module ct_fadd_close_lza_pipe #(
  parameter int WIDTH = 11,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                          forever_cpuclk,
  input  logic                          cpurst,
  ct_fadd_close_lza_pipe_if.slave       bus
);

  localparam int W = WIDTH;

  // EX1 combinational results
  logic [W:0]       d0;
  logic [W:0]       d1;
  logic             ex1_op_chg;
  logic             ex1_eq;
  logic [W-1:0]     ex1_sum;

  logic [W-1:0]     lza_c;
  logic [W-1:2]     lza_t;
  logic [W-1:0]     lza_g;
  logic [W-1:0]     lza_z;
  logic [W-1:0]     lza_f;
  logic [CNT_W-1:0] ex1_pred;

  // EX2 pipeline registers
  logic             ex2_vld_q;
  logic [W-1:0]     ex2_sum_q;
  logic             ex2_op_chg_q;
  logic             ex2_eq_q;
  logic [CNT_W-1:0] ex2_pred_q;

  // EX2 combinational results
  logic [W-1:0]     shifted;
  logic [W-1:0]     norm_d;
  logic [CNT_W-1:0] lz_d;
  logic             zero_d;
  logic             corr_d;

  // EX3 pipeline registers
  logic             ex3_vld_q;
  logic [W-1:0]     ex3_norm_q;
  logic [CNT_W-1:0] ex3_lz_q;
  logic             ex3_zero_q;
  logic             ex3_op_chg_q;
  logic             ex3_corr_q;

  // Both differences in parallel; the borrow out of A-B picks the magnitude.
  always_comb begin
    d0         = {1'b0, bus.ex1_adder0} - {1'b0, bus.ex1_adder1};
    d1         = {1'b0, bus.ex1_adder1} - {1'b0, bus.ex1_adder0};
    ex1_op_chg = d0[W];
    ex1_sum    = ex1_op_chg ? d1[W-1:0] : d0[W-1:0];
    ex1_eq     = !d0[W] && !d1[W];
  end

  // LZA indicator on A + ~B; works for either sign of the difference, so it
  // runs in parallel with the subtractors instead of after them.
  always_comb begin
    lza_c = ~bus.ex1_adder1;
    lza_t = bus.ex1_adder0[W-1:2] ^ lza_c[W-1:2];
    lza_g = bus.ex1_adder0 & lza_c;
    lza_z = ~bus.ex1_adder0 & ~lza_c;
    lza_f = '0;
    lza_f[W-1] = (lza_g[W-1] & ~lza_z[W-2]) | (lza_z[W-1] & ~lza_g[W-2]);
    for (int i = 1; i <= W - 2; i++) begin
      lza_f[i] = ( lza_t[i+1] & ((lza_g[i] & ~lza_z[i-1]) | (lza_z[i] & ~lza_g[i-1])))
               | (~lza_t[i+1] & ((lza_g[i] & ~lza_g[i-1]) | (lza_z[i] & ~lza_z[i-1])));
    end
    lza_f[0] = lza_g[0] | lza_z[0];
  end

  // Leading-zero count of the indicator; highest set bit wins, 0 when f is empty.
  always_comb begin
    ex1_pred = '0;
    for (int i = 0; i < W; i++) begin
      if (lza_f[i]) ex1_pred = CNT_W'(W - 1 - i);
    end
  end

  // EX1->EX2 register: flush kills the valid even under stall; data loads only with a valid.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      ex2_vld_q    <= 1'b0;
      ex2_sum_q    <= '0;
      ex2_op_chg_q <= 1'b0;
      ex2_eq_q     <= 1'b0;
      ex2_pred_q   <= '0;
    end else if (bus.pipe_flush) begin
      ex2_vld_q    <= 1'b0;
    end else if (!bus.pipe_stall) begin
      ex2_vld_q    <= bus.ex1_vld;
      if (bus.ex1_vld) begin
        ex2_sum_q    <= ex1_sum;
        ex2_op_chg_q <= ex1_op_chg;
        ex2_eq_q     <= ex1_eq;
        ex2_pred_q   <= ex1_pred;
      end
    end
  end

  // Normalise by the prediction; if the MSB is still clear the prediction was
  // one short, so shift once more and report the correction.
  always_comb begin
    shifted = ex2_sum_q << ex2_pred_q;
    norm_d  = shifted;
    lz_d    = ex2_pred_q;
    zero_d  = 1'b0;
    corr_d  = 1'b0;
    if (ex2_eq_q) begin
      norm_d = '0;
      lz_d   = '0;
      zero_d = 1'b1;
    end else if (!shifted[W-1]) begin
      norm_d = shifted << 1;
      lz_d   = ex2_pred_q + CNT_W'(1);
      corr_d = 1'b1;
    end
  end

  // EX2->EX3 register, same flush/stall/valid rules as the first stage.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      ex3_vld_q    <= 1'b0;
      ex3_norm_q   <= '0;
      ex3_lz_q     <= '0;
      ex3_zero_q   <= 1'b0;
      ex3_op_chg_q <= 1'b0;
      ex3_corr_q   <= 1'b0;
    end else if (bus.pipe_flush) begin
      ex3_vld_q    <= 1'b0;
    end else if (!bus.pipe_stall) begin
      ex3_vld_q    <= ex2_vld_q;
      if (ex2_vld_q) begin
        ex3_norm_q   <= norm_d;
        ex3_lz_q     <= lz_d;
        ex3_zero_q   <= zero_d;
        ex3_op_chg_q <= ex2_op_chg_q;
        ex3_corr_q   <= corr_d;
      end
    end
  end

  assign bus.ex2_vld      = ex2_vld_q;
  assign bus.ex2_sum      = ex2_sum_q;
  assign bus.ex2_op_chg   = ex2_op_chg_q;
  assign bus.ex2_eq       = ex2_eq_q;
  assign bus.ex2_ff1_pred = ex2_pred_q;

  assign bus.ex3_vld      = ex3_vld_q;
  assign bus.ex3_norm_sum = ex3_norm_q;
  assign bus.ex3_lz_cnt   = ex3_lz_q;
  assign bus.ex3_zero     = ex3_zero_q;
  assign bus.ex3_op_chg   = ex3_op_chg_q;
  assign bus.ex3_lza_corr = ex3_corr_q;

endmodule

// File: tb/tb_ct_fadd_close_lza_pipe.sv
// Bench for the close-path subtractor: hand-computed vectors at WIDTH=11,
// stall/flush/reset sequences, and a model-checked sweep at WIDTH=11 and 53.
module tb_ct_fadd_close_lza_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ct_fadd_close_lza_pipe_if #(.WIDTH(11)) b11 ();
  ct_fadd_close_lza_pipe_if #(.WIDTH(53)) b53 ();

  ct_fadd_close_lza_pipe #(.WIDTH(11)) dut11 (
    .forever_cpuclk(clk), .cpurst(rst), .bus(b11.slave)
  );
  ct_fadd_close_lza_pipe #(.WIDTH(53)) dut53 (
    .forever_cpuclk(clk), .cpurst(rst), .bus(b53.slave)
  );

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [10:0] a;
    logic [10:0] b;
    logic [10:0] sum;
    logic        op_chg;
    logic        eq;
    logic [3:0]  pred;
    logic [10:0] norm;
    logic [3:0]  lz;
    logic        zero;
    logic        corr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive11(input logic vld, input logic [10:0] a, input logic [10:0] b);
    b11.ex1_vld    = vld;
    b11.ex1_adder0 = a;
    b11.ex1_adder1 = b;
  endtask

  // Behavioural leading-one anticipator straight from the indicator equations.
  function automatic int m_pred(input logic [63:0] a, input logic [63:0] b, input int w);
    logic [63:0] c, t, g, z, f;
    c = ~b;
    t = a ^ c;
    g = a & c;
    z = ~a & ~c;
    f = '0;
    f[w-1] = (g[w-1] & ~z[w-2]) | (z[w-1] & ~g[w-2]);
    for (int i = 1; i <= w - 2; i++)
      f[i] = ( t[i+1] & ((g[i] & ~z[i-1]) | (z[i] & ~g[i-1])))
           | (~t[i+1] & ((g[i] & ~g[i-1]) | (z[i] & ~z[i-1])));
    f[0] = g[0] | z[0];
    for (int i = w - 1; i >= 0; i--)
      if (f[i]) return w - 1 - i;
    return 0;
  endfunction

  function automatic int m_clz(input logic [63:0] x, input int w);
    for (int i = w - 1; i >= 0; i--)
      if (x[i]) return w - 1 - i;
    return w;
  endfunction

  initial begin
    logic [63:0] a, b, mag, nrm;
    int pr, cz;

    //              a       b       sum     op    eq    pred   norm    lz     zero  corr
    vecs[0] = '{11'h400, 11'h3FF, 11'h001, 1'b0, 1'b0, 4'd10, 11'h400, 4'd10, 1'b0, 1'b0};
    vecs[1] = '{11'h200, 11'h300, 11'h100, 1'b1, 1'b0, 4'd2,  11'h400, 4'd2,  1'b0, 1'b0};
    vecs[2] = '{11'h555, 11'h555, 11'h000, 1'b0, 1'b1, 4'd0,  11'h000, 4'd0,  1'b1, 1'b0};
    vecs[3] = '{11'h400, 11'h001, 11'h3FF, 1'b0, 1'b0, 4'd0,  11'h7FE, 4'd1,  1'b0, 1'b1};
    vecs[4] = '{11'h001, 11'h400, 11'h3FF, 1'b1, 1'b0, 4'd0,  11'h7FE, 4'd1,  1'b0, 1'b1};
    vecs[5] = '{11'h7FF, 11'h000, 11'h7FF, 1'b0, 1'b0, 4'd0,  11'h7FF, 4'd0,  1'b0, 1'b0};
    vecs[6] = '{11'h000, 11'h000, 11'h000, 1'b0, 1'b1, 4'd0,  11'h000, 4'd0,  1'b1, 1'b0};
    vecs[7] = '{11'h003, 11'h001, 11'h002, 1'b0, 1'b0, 4'd9,  11'h400, 4'd9,  1'b0, 1'b0};

    drive11(1'b0, '0, '0);
    b11.pipe_stall = 1'b0;
    b11.pipe_flush = 1'b0;
    b53.ex1_vld = 1'b0; b53.ex1_adder0 = '0; b53.ex1_adder1 = '0;
    b53.pipe_stall = 1'b0;
    b53.pipe_flush = 1'b0;

    #12;
    chk("rst_ex2_vld", b11.ex2_vld, 0);
    chk("rst_ex2_sum", b11.ex2_sum, 0);
    chk("rst_ex2_pred", b11.ex2_ff1_pred, 0);
    chk("rst_ex3_vld", b11.ex3_vld, 0);
    chk("rst_ex3_norm", b11.ex3_norm_sum, 0);
    chk("rst_ex3_lz", b11.ex3_lz_cnt, 0);
    chk("rst_ex3_zero", b11.ex3_zero, 0);
    #2 rst = 1'b0;
    step();

    // directed table, one operand pair at a time
    foreach (vecs[k]) begin
      drive11(1'b1, vecs[k].a, vecs[k].b);
      step();
      drive11(1'b0, 11'h7AB, 11'h123);
      chk($sformatf("v%0d_ex2_vld", k), b11.ex2_vld, 1);
      chk($sformatf("v%0d_ex2_sum", k), b11.ex2_sum, vecs[k].sum);
      chk($sformatf("v%0d_ex2_op_chg", k), b11.ex2_op_chg, vecs[k].op_chg);
      chk($sformatf("v%0d_ex2_eq", k), b11.ex2_eq, vecs[k].eq);
      chk($sformatf("v%0d_ex2_pred", k), b11.ex2_ff1_pred, vecs[k].pred);
      step();
      chk($sformatf("v%0d_ex3_vld", k), b11.ex3_vld, 1);
      chk($sformatf("v%0d_ex3_norm", k), b11.ex3_norm_sum, vecs[k].norm);
      chk($sformatf("v%0d_ex3_lz", k), b11.ex3_lz_cnt, vecs[k].lz);
      chk($sformatf("v%0d_ex3_zero", k), b11.ex3_zero, vecs[k].zero);
      chk($sformatf("v%0d_ex3_op_chg", k), b11.ex3_op_chg, vecs[k].op_chg);
      chk($sformatf("v%0d_ex3_corr", k), b11.ex3_lza_corr, vecs[k].corr);
      chk($sformatf("v%0d_bubble_vld", k), b11.ex2_vld, 0);
      chk($sformatf("v%0d_bubble_stale", k), b11.ex2_sum, vecs[k].sum);
    end
    step();

    // back-to-back: three pairs on consecutive cycles
    drive11(1'b1, vecs[0].a, vecs[0].b); step();
    chk("b2b_ex2_sum0", b11.ex2_sum, 11'h001);
    drive11(1'b1, vecs[1].a, vecs[1].b); step();
    chk("b2b_ex2_sum1", b11.ex2_sum, 11'h100);
    chk("b2b_ex3_vld0", b11.ex3_vld, 1);
    chk("b2b_ex3_lz0", b11.ex3_lz_cnt, 10);
    drive11(1'b1, vecs[2].a, vecs[2].b); step();
    chk("b2b_ex2_eq2", b11.ex2_eq, 1);
    chk("b2b_ex2_vld2", b11.ex2_vld, 1);
    chk("b2b_ex3_lz1", b11.ex3_lz_cnt, 2);
    chk("b2b_ex3_op1", b11.ex3_op_chg, 1);
    drive11(1'b0, '0, '0); step();
    chk("b2b_ex3_zero2", b11.ex3_zero, 1);
    chk("b2b_ex3_vld2", b11.ex3_vld, 1);
    step(); step();

    // stall for three cycles after a capture; upstream inputs change but must be ignored
    drive11(1'b1, 11'h200, 11'h300); step();
    b11.pipe_stall = 1'b1;
    drive11(1'b1, 11'h7FF, 11'h001);
    for (int s = 0; s < 3; s++) begin
      step();
      chk($sformatf("stall%0d_ex2_vld", s), b11.ex2_vld, 1);
      chk($sformatf("stall%0d_ex2_sum", s), b11.ex2_sum, 11'h100);
      chk($sformatf("stall%0d_ex3_vld", s), b11.ex3_vld, 0);
    end
    b11.pipe_stall = 1'b0;
    drive11(1'b0, '0, '0); step();
    chk("stall_rel_ex3_vld", b11.ex3_vld, 1);
    chk("stall_rel_ex3_norm", b11.ex3_norm_sum, 11'h400);
    chk("stall_rel_ex2_vld", b11.ex2_vld, 0);
    step();

    // flush with stall and a new valid, both stages full
    drive11(1'b1, vecs[0].a, vecs[0].b); step();
    drive11(1'b1, vecs[1].a, vecs[1].b); step();
    chk("flush_pre_ex2_vld", b11.ex2_vld, 1);
    chk("flush_pre_ex3_vld", b11.ex3_vld, 1);
    b11.pipe_flush = 1'b1;
    b11.pipe_stall = 1'b1;
    drive11(1'b1, vecs[3].a, vecs[3].b); step();
    chk("flush_ex2_vld", b11.ex2_vld, 0);
    chk("flush_ex3_vld", b11.ex3_vld, 0);
    b11.pipe_flush = 1'b0;
    b11.pipe_stall = 1'b0;
    drive11(1'b0, '0, '0); step();
    chk("flush_after_ex3_vld", b11.ex3_vld, 0);

    // asynchronous reset mid-stream
    drive11(1'b1, vecs[3].a, vecs[3].b); step();
    drive11(1'b1, vecs[4].a, vecs[4].b); step();
    #2 rst = 1'b1;
    #1;
    chk("arst_ex2_vld", b11.ex2_vld, 0);
    chk("arst_ex2_sum", b11.ex2_sum, 0);
    chk("arst_ex2_op_chg", b11.ex2_op_chg, 0);
    chk("arst_ex3_vld", b11.ex3_vld, 0);
    chk("arst_ex3_norm", b11.ex3_norm_sum, 0);
    chk("arst_ex3_corr", b11.ex3_lza_corr, 0);
    drive11(1'b0, '0, '0);
    step();
    rst = 1'b0;
    step();
    chk("arst_post_ex2_vld", b11.ex2_vld, 0);
    step();
    chk("arst_post_ex3_vld", b11.ex3_vld, 0);

    // model-checked sweep, WIDTH=11 and WIDTH=53 in lockstep
    for (int k = 0; k < 60; k++) begin
      logic [10:0] a11, b11v;
      logic [52:0] a53, b53v;
      a11  = 11'($urandom);
      b11v = (k % 10 == 0) ? a11 : ((k % 7 == 0) ? a11 ^ 11'h001 : 11'($urandom));
      a53  = 53'({$urandom, $urandom});
      b53v = (k % 10 == 0) ? a53 : ((k % 9 == 0) ? a53 ^ (53'd1 << (k % 53)) : 53'({$urandom, $urandom}));
      drive11(1'b1, a11, b11v);
      b53.ex1_vld = 1'b1; b53.ex1_adder0 = a53; b53.ex1_adder1 = b53v;
      step();
      drive11(1'b0, '0, '0);
      b53.ex1_vld = 1'b0;

      for (int w = 0; w < 2; w++) begin
        int ww;
        ww  = (w == 0) ? 11 : 53;
        a   = (w == 0) ? 64'(a11)  : 64'(a53);
        b   = (w == 0) ? 64'(b11v) : 64'(b53v);
        mag = (a >= b) ? a - b : b - a;
        pr  = m_pred(a, b, ww);
        if (w == 0) begin
          chk($sformatf("sw%0d_w11_sum", k), b11.ex2_sum, mag);
          chk($sformatf("sw%0d_w11_op", k), b11.ex2_op_chg, b > a);
          chk($sformatf("sw%0d_w11_pred", k), b11.ex2_ff1_pred, pr);
        end else begin
          chk($sformatf("sw%0d_w53_sum", k), b53.ex2_sum, mag);
          chk($sformatf("sw%0d_w53_op", k), b53.ex2_op_chg, b > a);
          chk($sformatf("sw%0d_w53_pred", k), b53.ex2_ff1_pred, pr);
        end
      end
      step();
      for (int w = 0; w < 2; w++) begin
        int ww;
        logic [63:0] n_act, lz_act, z_act, c_act;
        ww  = (w == 0) ? 11 : 53;
        a   = (w == 0) ? 64'(a11)  : 64'(a53);
        b   = (w == 0) ? 64'(b11v) : 64'(b53v);
        mag = (a >= b) ? a - b : b - a;
        pr  = m_pred(a, b, ww);
        cz  = m_clz(mag, ww);
        n_act  = (w == 0) ? 64'(b11.ex3_norm_sum) : 64'(b53.ex3_norm_sum);
        lz_act = (w == 0) ? 64'(b11.ex3_lz_cnt)   : 64'(b53.ex3_lz_cnt);
        z_act  = (w == 0) ? 64'(b11.ex3_zero)     : 64'(b53.ex3_zero);
        c_act  = (w == 0) ? 64'(b11.ex3_lza_corr) : 64'(b53.ex3_lza_corr);
        if (mag == 0) begin
          chk($sformatf("sw%0d_w%0d_zero", k, ww), z_act, 1);
          chk($sformatf("sw%0d_w%0d_norm0", k, ww), n_act, 0);
          chk($sformatf("sw%0d_w%0d_lz0", k, ww), lz_act, 0);
          chk($sformatf("sw%0d_w%0d_corr0", k, ww), c_act, 0);
        end else begin
          nrm = (mag << cz) & ((64'd1 << ww) - 1);
          chk($sformatf("sw%0d_w%0d_zero", k, ww), z_act, 0);
          chk($sformatf("sw%0d_w%0d_lz", k, ww), lz_act, cz);
          chk($sformatf("sw%0d_w%0d_corr", k, ww), c_act, (pr != cz) ? 1 : 0);
          chk($sformatf("sw%0d_w%0d_norm", k, ww), n_act, nrm);
          chk($sformatf("sw%0d_w%0d_msb", k, ww), n_act[ww-1], 1);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
